fir_tap_loader: RTL
===================

Name: fir_tap_loader

Overview:
- Controller that owns configuration and sequencing of one configurable_fir instance.
- Stores G_NUM_PROFILES coefficient sets in a local RAM, written by a config port.
- On request, quiesces the FIR, drops its enable to force re-init, and streams the selected profile's T = 2^(G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2) taps into the FIR tap port.
- Gates the upstream sample stream so samples only reach the FIR while it is programmed and running.

Parameters:
- G_NUM_STAGES_LOG2, 2, FIR stage count log2; must match the FIR.
- G_STAGE_DEPTH_LOG2, 2, FIR stage depth log2; must match the FIR.
- G_TAP_WIDTH, 16, coefficient width.
- G_DATA_WIDTH, 16, sample width.
- G_NUM_PROFILES_LOG2, 1, log2 of the number of stored coefficient sets.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cfg_wr_profile  in  G_NUM_PROFILES_LOG2  profile index for a coefficient write.
- cfg_wr_addr  in  TL=G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2  tap index within the profile.
- cfg_wr_value  in  G_TAP_WIDTH  coefficient value.
- cfg_wr_valid  in  1  coefficient write strobe.
- cfg_wr_ready  out  1  low while the addressed profile is being loaded.
- load_profile  in  G_NUM_PROFILES_LOG2  profile to program.
- load_req  in  1  one-cycle program request.
- load_busy  out  1  high in DRAIN, FLUSH and LOAD.
- active_profile  out  G_NUM_PROFILES_LOG2  last profile fully loaded.
- running  out  1  high in RUN.
- fir_enable  out  1  drives the FIR enable.
- fir_tap_dout  out  G_TAP_WIDTH  tap stream data.
- fir_tap_valid  out  1  tap stream valid.
- fir_tap_ready  in  1  tap stream ready.
- s_din, s_din_valid, s_din_ready  in/in/out  G_DATA_WIDTH/1/1  upstream sample stream.
- fir_din, fir_din_valid, fir_din_ready  out/out/in  G_DATA_WIDTH/1/1  sample stream to the FIR.
- fir_dout_valid, fir_dout_ready  in/in  1/1  monitor taps of the FIR output handshake.

Behaviour:
- Reset values:
  - state IDLE.
  - fir_enable=0, fir_tap_valid=0, fir_tap_dout=0.
  - load_busy=0, running=0, active_profile=0, cfg_wr_ready=1.
  - in-flight counter = 0, flush counter = 0.
- Coefficient RAM:
  - Depth 2^(G_NUM_PROFILES_LOG2+TL), address {profile, addr}.
  - Write on cfg_wr_valid & cfg_wr_ready.
  - Read latency 1 cycle.
- Sample gate (combinational):
  - fir_din = s_din.
  - fir_din_valid = s_din_valid & running.
  - s_din_ready = fir_din_ready & running.
- In-flight counter (2 bits):
  - +1 on fir_din handshake.
  - -1 on fir_dout_valid & fir_dout_ready.
  - Both in the same cycle: unchanged.
- States:
  - IDLE: fir_enable=0.
    - load_req → latch load_profile into target → FLUSH (the FIR is already disabled, so no drain is needed).
  - RUN: fir_enable=1, running=1.
    - load_req → latch target, running drops the next cycle → DRAIN.
  - DRAIN: sample gate closed, fir_enable=1.
    - When in-flight=0 → FLUSH.
    - Also left after 2^16 cycles via a timeout; a partial output is discarded by the disable.
  - FLUSH: fir_enable=0 for exactly 2 cycles, then fir_enable=1 → LOAD.
  - LOAD: fir_enable=1, taps streamed for index 0..T-1 of the target profile.
    - Bursts at 1 tap/cycle while fir_tap_ready is high. This requires a 2-entry skid buffer behind the RAM read.
    - fir_tap_valid is never deasserted mid-burst while data is buffered.
    - fir_tap_dout is stable while valid & !ready.
    - After handshake of tap T-1: active_profile <= target → RUN.
- load_req while load_busy: ignored, no queueing.
- cfg_wr_ready = !(load_busy & cfg_wr_profile==target).
- Writes to other profiles are always accepted.
- The FIR is considered programmed only after exactly T tap handshakes; the tap count is compared, not any FIR status output.
- reset mid-LOAD: all outputs return to reset values, the FIR is left disabled, and RAM contents are retained.

Decomposition:
- Package fir_tap_loader_pkg holds:
  - state enum (IDLE, DRAIN, FLUSH, LOAD, RUN).
  - FLUSH_CYCLES=2.
  - DRAIN_TIMEOUT=65535.
  - function computing TL.
- One sub-module, fir_coef_ram: simple dual-port, 1-cycle read, no reset on the array.

Test Plan:
- Write profile 0 taps 1..16 (T=16), pulse load_req profile 0, fir_tap_ready=1 → FLUSH 2 cycles, then 16 consecutive tap handshakes carrying values 1..16, running=1, active_profile=0.
- Same load with fir_tap_ready toggling 1,0,1,0 → tap order 1..16 preserved, fir_tap_dout stable during stalls, exactly 16 handshakes.
- RUN with one sample accepted and output pending, load_req profile 1 → s_din_ready=0 immediately after, fir_enable stays 1 until fir_dout handshake, then FLUSH; profile 1 taps follow.
- During LOAD of profile 1: cfg write to profile 1 → cfg_wr_ready=0, RAM unchanged; cfg write to profile 0 → accepted.
- load_req asserted in LOAD → ignored, active_profile unchanged until the current load completes.
- reset asserted at tap 7 of LOAD → next cycle fir_tap_valid=0, fir_enable=0, state IDLE; a new load_req reloads all 16 taps from tap 0.

Source files
------------

// File: rtl/fir_tap_loader_pkg.sv
// -----------------------------------------------------------------------------
// fir_tap_loader_pkg
// Shared types and constants for the FIR tap loader:
//   state_e       controller states
//   FLUSH_CYCLES  cycles the FIR enable is held low to force a re-init
//   DRAIN_TIMEOUT last drain-counter value before the drain is abandoned
//   calc_tl()     log2 of the FIR tap count (stage count log2 + depth log2)
// -----------------------------------------------------------------------------
package fir_tap_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH,
        LOAD,
        RUN
    } state_e;

    localparam int FLUSH_CYCLES  = 2;
    localparam int DRAIN_TIMEOUT = 65535;

    function automatic int calc_tl(input int num_stages_log2, input int stage_depth_log2);
        return num_stages_log2 + stage_depth_log2;
    endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// -----------------------------------------------------------------------------
// fir_coef_ram
// Simple dual-port coefficient store, one write port and one read port,
// read data registered (1-cycle latency).
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; rd_data_o updates on the following cycle
//   rd_addr_i  read address
//   rd_data_o  registered read data
// -----------------------------------------------------------------------------
module fir_coef_ram #(
    parameter int G_ADDR_WIDTH = 5,
    parameter int G_DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    wr_en_i,
    input  logic [G_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [G_DATA_WIDTH-1:0] wr_data_i,
    input  logic                    rd_en_i,
    input  logic [G_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [G_DATA_WIDTH-1:0] rd_data_o
);

    logic [G_DATA_WIDTH-1:0] mem_q [2**G_ADDR_WIDTH];
    logic [G_DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM and keeps its
    // contents across a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// -----------------------------------------------------------------------------
// fir_tap_loader
// Owns the configuration and sequencing of one configurable_fir. Holds
// 2^G_NUM_PROFILES_LOG2 coefficient profiles in a local RAM and, on load_req,
// drains the FIR, pulses its enable low to force re-init, and streams the
// selected profile's T taps into the FIR tap port. Upstream samples are gated
// through only while the FIR is programmed and running.
//   clk, reset                  clock, synchronous active-high reset
//   cfg_wr_*                    coefficient write port (profile, tap index, value)
//   load_profile, load_req      program request
//   load_busy, running          status; active_profile = last fully loaded profile
//   fir_enable                  FIR enable
//   fir_tap_dout/valid/ready    tap stream to the FIR
//   s_din/_valid/_ready         upstream sample stream
//   fir_din/_valid/_ready       sample stream to the FIR
//   fir_dout_valid/_ready       monitor of the FIR output handshake
// -----------------------------------------------------------------------------
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int G_NUM_STAGES_LOG2   = 2,
    parameter int G_STAGE_DEPTH_LOG2  = 2,
    parameter int G_TAP_WIDTH         = 16,
    parameter int G_DATA_WIDTH        = 16,
    parameter int G_NUM_PROFILES_LOG2 = 1,
    localparam int TL = calc_tl(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [G_NUM_PROFILES_LOG2-1:0] cfg_wr_profile,
    input  logic [TL-1:0]                  cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]         cfg_wr_value,
    input  logic                           cfg_wr_valid,
    output logic                           cfg_wr_ready,
    input  logic [G_NUM_PROFILES_LOG2-1:0] load_profile,
    input  logic                           load_req,
    output logic                           load_busy,
    output logic [G_NUM_PROFILES_LOG2-1:0] active_profile,
    output logic                           running,
    output logic                           fir_enable,
    output logic [G_TAP_WIDTH-1:0]         fir_tap_dout,
    output logic                           fir_tap_valid,
    input  logic                           fir_tap_ready,
    input  logic [G_DATA_WIDTH-1:0]        s_din,
    input  logic                           s_din_valid,
    output logic                           s_din_ready,
    output logic [G_DATA_WIDTH-1:0]        fir_din,
    output logic                           fir_din_valid,
    input  logic                           fir_din_ready,
    input  logic                           fir_dout_valid,
    input  logic                           fir_dout_ready
);

    localparam int T = 1 << TL;
    localparam int PW = G_NUM_PROFILES_LOG2;

    typedef logic [TL:0] cnt_t;
    localparam cnt_t T_CNT  = T[TL:0];
    localparam cnt_t T_LAST = T_CNT - cnt_t'(1);

    state_e                  state_q, state_d;
    logic [PW-1:0]           target_q, target_d;
    logic [PW-1:0]           active_q, active_d;
    logic [1:0]              flush_cnt_q, flush_cnt_d;
    logic [15:0]             drain_cnt_q, drain_cnt_d;
    logic [1:0]              inflight_q, inflight_d;
    cnt_t                    rd_idx_q, rd_idx_d;
    cnt_t                    hs_cnt_q, hs_cnt_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [1:0]              buf_cnt_q, buf_cnt_d;
    logic [G_TAP_WIDTH-1:0]  buf0_q, buf0_d;
    logic [G_TAP_WIDTH-1:0]  buf1_q, buf1_d;

    logic [G_TAP_WIDTH-1:0]  ram_rd_data;
    logic                    tap_rd_en;
    logic                    tap_pop;
    logic [2:0]              occupancy;
    logic                    din_hs;
    logic                    dout_hs;

    // Status and gating, all decoded from the registered state.
    assign load_busy      = (state_q == DRAIN) || (state_q == FLUSH) || (state_q == LOAD);
    assign running        = (state_q == RUN);
    assign fir_enable     = (state_q == RUN) || (state_q == DRAIN) || (state_q == LOAD);
    assign active_profile = active_q;
    assign cfg_wr_ready   = !(load_busy && (cfg_wr_profile == target_q));

    assign fir_din       = s_din;
    assign fir_din_valid = s_din_valid & running;
    assign s_din_ready   = fir_din_ready & running;
    assign din_hs        = fir_din_valid & fir_din_ready;
    assign dout_hs       = fir_dout_valid & fir_dout_ready;

    // The skid buffer head is the tap presented to the FIR.
    assign fir_tap_valid = (state_q == LOAD) && (buf_cnt_q != 2'd0);
    assign fir_tap_dout  = buf0_q;
    assign tap_pop       = fir_tap_valid & fir_tap_ready;

    // A read is issued only if its data is guaranteed a slot next cycle:
    // buffered entries plus the read already in flight, minus this cycle's pop.
    assign occupancy = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q};
    assign tap_rd_en = (state_q == LOAD) && (rd_idx_q != T_CNT)
                       && ((occupancy - {2'b00, tap_pop}) < 3'd2);

    fir_coef_ram #(
        .G_ADDR_WIDTH (PW + TL),
        .G_DATA_WIDTH (G_TAP_WIDTH)
    ) u_coef_ram (
        .clk       (clk),
        .wr_en_i   (cfg_wr_valid & cfg_wr_ready),
        .wr_addr_i ({cfg_wr_profile, cfg_wr_addr}),
        .wr_data_i (cfg_wr_value),
        .rd_en_i   (tap_rd_en),
        .rd_addr_i ({target_q, rd_idx_q[TL-1:0]}),
        .rd_data_o (ram_rd_data)
    );

    // Samples accepted by the FIR but not yet emitted; cleared whenever the
    // FIR is disabled because the disable discards its pipeline.
    always_comb begin
        inflight_d = inflight_q;
        if (!fir_enable) begin
            inflight_d = '0;
        end else if (din_hs && !dout_hs) begin
            inflight_d = inflight_q + 2'd1;
        end else if (!din_hs && dout_hs && (inflight_q != 2'd0)) begin
            inflight_d = inflight_q - 2'd1;
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        target_d    = target_q;
        active_d    = active_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;
        rd_idx_d    = rd_idx_q;
        hs_cnt_d    = hs_cnt_q;
        rd_pend_d   = 1'b0;
        buf_cnt_d   = buf_cnt_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        case (state_q)
            IDLE: begin
                // FIR is already disabled, so go straight to the flush.
                if (load_req) begin
                    target_d    = load_profile;
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end
            end
            RUN: begin
                if (load_req) begin
                    target_d    = load_profile;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 16'd1;
                if ((inflight_q == 2'd0) || (drain_cnt_q == 16'(DRAIN_TIMEOUT))) begin
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 2'd1;
                rd_idx_d    = '0;
                hs_cnt_d    = '0;
                buf_cnt_d   = '0;
                if (flush_cnt_q == 2'(FLUSH_CYCLES - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_pend_d = tap_rd_en;
                if (tap_rd_en) begin
                    rd_idx_d = rd_idx_q + cnt_t'(1);
                end
                // Two-entry skid buffer: buf0 is the head, buf1 the overflow.
                case ({rd_pend_q, tap_pop})
                    2'b10: begin
                        if (buf_cnt_q == 2'd0) buf0_d = ram_rd_data;
                        else                   buf1_d = ram_rd_data;
                        buf_cnt_d = buf_cnt_q + 2'd1;
                    end
                    2'b01: begin
                        buf0_d    = buf1_q;
                        buf_cnt_d = buf_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (buf_cnt_q == 2'd1) begin
                            buf0_d = ram_rd_data;
                        end else begin
                            buf0_d = buf1_q;
                            buf1_d = ram_rd_data;
                        end
                    end
                    default: ;
                endcase
                // Programmed only after exactly T accepted taps.
                if (tap_pop) begin
                    hs_cnt_d = hs_cnt_q + cnt_t'(1);
                    if (hs_cnt_q == T_LAST) begin
                        active_d = target_q;
                        state_d  = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            active_q    <= '0;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
            inflight_q  <= '0;
            rd_idx_q    <= '0;
            hs_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            buf_cnt_q   <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            active_q    <= active_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            inflight_q  <= inflight_d;
            rd_idx_q    <= rd_idx_d;
            hs_cnt_q    <= hs_cnt_d;
            rd_pend_q   <= rd_pend_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

endmodule
